pool1: RTL

Downstream stage of the first convolution layer. It accepts the streamed 16-bit signed conv results (channel-major, row-major, 14×13 per channel, 10 channels) and applies ReLU, requantisation to 8-bit unsigned and 2×2/stride-2 max-pooling. It emits a 7×6×10 feature map as an addressed pixel stream for the next layer's input buffer.

---
 rtl/npu_pkg.sv | 31 +++
 rtl/pool1_if.sv | 30 +++
 rtl/relu_quant.sv | 30 +++
 rtl/pool1.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_pkg
// Description : Shared layer dimensions, pixel types and helpers for the NPU.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_pkg;

    localparam int CONV1_OUT_H  = 14;
    localparam int CONV1_OUT_W  = 13;
    localparam int CONV1_CHAN   = 10;
    localparam int POOL1_OUT_H  = 7;
    localparam int POOL1_OUT_W  = 6;
    localparam int POOL1_SHIFT  = 4;
    localparam int POOL1_ADDR_W = 9;

    typedef logic        [7:0]  pix8_t;
    typedef logic signed [15:0] acc16_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } pool1_state_t;

    function automatic pix8_t max_pix(input pix8_t a, input pix8_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool1_if.sv
`default_nettype none
// ============================================================================
// Module      : pool1_if
// Description : Conv-result input stream and addressed pooled-pixel output.
// Revision    : 1.0 - initial release
// ============================================================================
interface pool1_if;
    import npu_pkg::*;

    logic                    start;
    logic                    in_valid;
    acc16_t                  in_pixel;
    logic                    out_valid;
    pix8_t                   out_pixel;
    logic [POOL1_ADDR_W-1:0] out_addr;
    logic                    busy;
    logic                    done;

    modport master (
        output start, in_valid, in_pixel,
        input  out_valid, out_pixel, out_addr, busy, done
    );

    modport slave (
        input  start, in_valid, in_pixel,
        output out_valid, out_pixel, out_addr, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/relu_quant.sv
`default_nettype none
// ============================================================================
// Module      : relu_quant
// Description : ReLU plus right-shift requantisation to saturated 8-bit.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_quant
    import npu_pkg::*;
#(
    parameter int SHIFT = POOL1_SHIFT
) (
    input  acc16_t i_pixel,
    output pix8_t  o_q
);

    acc16_t w_shifted;

    always_comb begin
        w_shifted = i_pixel >>> SHIFT;
        if (i_pixel[15]) begin
            o_q = '0;
        end else if (|w_shifted[15:8]) begin
            o_q = 8'hFF;
        end else begin
            o_q = w_shifted[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool1.sv
`default_nettype none
// ============================================================================
// Module      : pool1
// Description : ReLU/requantise and 2x2 stride-2 max-pool of conv1 results.
// Revision    : 1.0 - initial release
// ============================================================================
module pool1
    import npu_pkg::*;
#(
    parameter int IN_H  = CONV1_OUT_H,
    parameter int IN_W  = CONV1_OUT_W,
    parameter int CHAN  = CONV1_CHAN,
    parameter int SHIFT = POOL1_SHIFT,
    parameter int OUT_H = IN_H / 2,
    parameter int OUT_W = IN_W / 2
) (
    input  logic   clk,
    input  logic   rst,
    pool1_if.slave bus
);

    localparam int c_col_w = (IN_W  > 1) ? $clog2(IN_W)  : 1;
    localparam int c_row_w = (IN_H  > 1) ? $clog2(IN_H)  : 1;
    localparam int c_ch_w  = (CHAN  > 1) ? $clog2(CHAN)  : 1;
    localparam int c_idx_w = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IN_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IN_H - 1);
    localparam logic [c_ch_w-1:0]  c_ch_last  = c_ch_w'(CHAN - 1);

    pool1_state_t              r_state_q,     w_state_d;
    logic [c_col_w-1:0]        r_col_q,       w_col_d;
    logic [c_row_w-1:0]        r_row_q,       w_row_d;
    logic [c_ch_w-1:0]         r_ch_q,        w_ch_d;
    logic [POOL1_ADDR_W-1:0]   r_out_cnt_q,   w_out_cnt_d;
    pix8_t                     r_hold_q,      w_hold_d;
    pix8_t [OUT_W-1:0]         r_rowbuf_q,    w_rowbuf_d;
    logic                      r_out_valid_q, w_out_valid_d;
    pix8_t                     r_out_pixel_q, w_out_pixel_d;
    logic [POOL1_ADDR_W-1:0]   r_out_addr_q,  w_out_addr_d;

    pix8_t                     w_q;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_in_win;
    logic                      w_last_beat;

    relu_quant #(
        .SHIFT (SHIFT)
    ) u_relu_quant (
        .i_pixel (bus.in_pixel),
        .o_q     (w_q)
    );

    // Trailing odd column/row has no partner and never enters a window.
    assign w_in_win    = (int'(r_col_q) < 2 * OUT_W) && (int'(r_row_q) < 2 * OUT_H);
    assign w_idx       = c_idx_w'(r_col_q >> 1);
    assign w_last_beat = (r_col_q == c_col_last) && (r_row_q == c_row_last) &&
                         (r_ch_q == c_ch_last);

    always_comb begin
        w_state_d     = r_state_q;
        w_col_d       = r_col_q;
        w_row_d       = r_row_q;
        w_ch_d        = r_ch_q;
        w_out_cnt_d   = r_out_cnt_q;
        w_hold_d      = r_hold_q;
        w_rowbuf_d    = r_rowbuf_q;
        w_out_valid_d = 1'b0;
        w_out_pixel_d = r_out_pixel_q;
        w_out_addr_d  = r_out_addr_q;

        unique case (r_state_q)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_d   = S_RUN;
                    w_col_d     = '0;
                    w_row_d     = '0;
                    w_ch_d      = '0;
                    w_out_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (bus.in_valid) begin
                    if (r_col_q == c_col_last) begin
                        w_col_d = '0;
                        if (r_row_q == c_row_last) begin
                            w_row_d = '0;
                            w_ch_d  = (r_ch_q == c_ch_last) ? '0 : r_ch_q + c_ch_w'(1);
                        end else begin
                            w_row_d = r_row_q + c_row_w'(1);
                        end
                    end else begin
                        w_col_d = r_col_q + c_col_w'(1);
                    end

                    if (w_in_win) begin
                        if (!r_col_q[0]) begin
                            w_hold_d = w_q;
                        end else if (!r_row_q[0]) begin
                            w_rowbuf_d[w_idx] = max_pix(r_hold_q, w_q);
                        end else begin
                            w_out_valid_d = 1'b1;
                            w_out_pixel_d = max_pix(max_pix(r_rowbuf_q[w_idx], r_hold_q), w_q);
                            w_out_addr_d  = r_out_cnt_q;
                            w_out_cnt_d   = r_out_cnt_q + POOL1_ADDR_W'(1);
                        end
                    end

                    if (w_last_beat) begin
                        w_state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_col_q       <= '0;
            r_row_q       <= '0;
            r_ch_q        <= '0;
            r_out_cnt_q   <= '0;
            r_hold_q      <= '0;
            r_rowbuf_q    <= '0;
            r_out_valid_q <= 1'b0;
            r_out_pixel_q <= '0;
            r_out_addr_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_col_q       <= w_col_d;
            r_row_q       <= w_row_d;
            r_ch_q        <= w_ch_d;
            r_out_cnt_q   <= w_out_cnt_d;
            r_hold_q      <= w_hold_d;
            r_rowbuf_q    <= w_rowbuf_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_pixel_q <= w_out_pixel_d;
            r_out_addr_q  <= w_out_addr_d;
        end
    end

    assign bus.out_valid = r_out_valid_q;
    assign bus.out_pixel = r_out_pixel_q;
    assign bus.out_addr  = r_out_addr_q;
    assign bus.busy      = (r_state_q == S_RUN);
    assign bus.done      = (r_state_q == S_DONE);

endmodule
`default_nettype wire
